// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the memory-mapped UART: bus op
//            codes, RX/TX state encodings, baud table and status bit map.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_CFG  = 2'b01,
    OP_POP  = 2'b10,
    OP_PUSH = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Bit positions inside the 8-bit status field
  localparam int STAT_OVR     = 7;
  localparam int STAT_FRM     = 6;
  localparam int STAT_PAR     = 5;
  localparam int STAT_IRQ_EN  = 4;
  localparam int STAT_SEL_LSB = 0;

  // Baud rate for a 4-bit select; codes above 7 fall back to 115200
  function automatic int unsigned baud_rate(input logic [3:0] sel);
    case (sel)
      4'd0:    return 9600;
      4'd1:    return 19200;
      4'd2:    return 38400;
      4'd3:    return 57600;
      4'd4:    return 115200;
      4'd5:    return 230400;
      4'd6:    return 460800;
      4'd7:    return 921600;
      default: return 115200;
    endcase
  endfunction

  // Clock cycles per bit, truncated; only ever called with constant arguments
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [3:0] sel);
    return clk_freq / baud_rate(sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : Show-ahead synchronous FIFO with occupancy count. The head entry
//            is visible on rdata (zero when empty). A push while full is only
//            accepted when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign count     = r_count;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_mmio
// Purpose  : 8-bit UART with op-coded register access, RX/TX FIFOs, eight
//            selectable baud rates, error flags and a level interrupt.
//            Optional parity is compiled in with UART_MMIO_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = 50000000,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter logic [3:0]  DEFAULT_BAUD_SEL = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int DIV_W = $clog2(CLK_FREQ / 9600 + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  // ---------------- configuration ----------------
  logic [3:0]       r_baud_sel;
  logic             r_irq_en;
  logic             w_cfg_par_en;
  logic             w_cfg_par_odd;
  logic [DIV_W-1:0] w_cfg_div;
  logic [DIV_W-1:0] w_div_table [16];
  logic             w_clr_err;

  // Divisor for every select code is a synthesis-time constant
  for (genvar g = 0; g < 16; g++) begin : g_div_table
    assign w_div_table[g] = DIV_W'(baud_div(CLK_FREQ, 4'(g)));
  end
  assign w_cfg_div = w_div_table[r_baud_sel];
  assign w_clr_err = (op == OP_CFG) & wdata[7];

  // Baud select and interrupt enable written by op=01
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_sel <= DEFAULT_BAUD_SEL;
      r_irq_en   <= 1'b0;
    end else if (op == OP_CFG) begin
      r_baud_sel <= wdata[3:0];
      r_irq_en   <= wdata[4];
    end
  end

`ifdef UART_MMIO_PARITY_EN
  logic r_parity_en;
  logic r_parity_odd;
  // Parity mode written by op=01
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_en  <= 1'b0;
      r_parity_odd <= 1'b0;
    end else if (op == OP_CFG) begin
      r_parity_en  <= wdata[5];
      r_parity_odd <= wdata[6];
    end
  end
  assign w_cfg_par_en  = r_parity_en;
  assign w_cfg_par_odd = r_parity_odd;
`else
  assign w_cfg_par_en  = 1'b0;
  assign w_cfg_par_odd = 1'b0;
`endif

  // ---------------- FIFOs ----------------
  logic [7:0]    w_tx_head;
  logic [7:0]    w_rx_head;
  logic [CW-1:0] w_tx_count;
  logic [CW-1:0] w_rx_count;
  logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_tx_pop;
  logic          r_rx_wr;
  logic [7:0]    r_rx_shift;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (op == OP_PUSH),
    .wdata (wdata[7:0]),
    .pop   (w_tx_pop),
    .rdata (w_tx_head),
    .count (w_tx_count),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_rx_wr),
    .wdata (r_rx_shift),
    .pop   (op == OP_POP),
    .rdata (w_rx_head),
    .count (w_rx_count),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_e        r_tx_state, w_tx_state_nx;
  logic [DIV_W-1:0] r_tx_cnt, w_tx_cnt_nx;
  logic [DIV_W-1:0] r_tx_div, w_tx_div_nx;
  logic [2:0]       r_tx_bit, w_tx_bit_nx;
  logic [7:0]       r_tx_shift, w_tx_shift_nx;
  logic             r_tx_par_en, w_tx_par_en_nx;
  logic             r_tx_par, w_tx_par_nx;
  logic             r_tx, w_tx_line;
  logic             w_tx_tick, w_tx_load;

  assign w_tx_tick = (r_tx_cnt == r_tx_div - DIV_W'(1));
  assign tx        = r_tx;

  // TX state and datapath registers; the line output is registered so it
  // switches exactly on the bit boundary and goes high at once on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_div    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_par    <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_tx_state  <= w_tx_state_nx;
      r_tx_cnt    <= w_tx_cnt_nx;
      r_tx_div    <= w_tx_div_nx;
      r_tx_bit    <= w_tx_bit_nx;
      r_tx_shift  <= w_tx_shift_nx;
      r_tx_par_en <= w_tx_par_en_nx;
      r_tx_par    <= w_tx_par_nx;
      r_tx        <= w_tx_line;
    end
  end

  // TX next state: a new frame is loaded from IDLE or straight out of STOP
  always_comb begin
    w_tx_state_nx  = r_tx_state;
    w_tx_cnt_nx    = r_tx_cnt + DIV_W'(1);
    w_tx_div_nx    = r_tx_div;
    w_tx_bit_nx    = r_tx_bit;
    w_tx_shift_nx  = r_tx_shift;
    w_tx_par_en_nx = r_tx_par_en;
    w_tx_par_nx    = r_tx_par;
    w_tx_load      = 1'b0;
    w_tx_pop       = 1'b0;
    w_tx_line      = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nx = '0;
        w_tx_load   = ~w_tx_empty;
      end
      TX_START: if (w_tx_tick) begin
        w_tx_cnt_nx   = '0;
        w_tx_bit_nx   = '0;
        w_tx_state_nx = TX_DATA;
      end
      TX_DATA: if (w_tx_tick) begin
        w_tx_cnt_nx   = '0;
        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
        w_tx_bit_nx   = r_tx_bit + 3'd1;
        if (r_tx_bit == 3'd7) w_tx_state_nx = r_tx_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (w_tx_tick) begin
        w_tx_cnt_nx   = '0;
        w_tx_state_nx = TX_STOP;
      end
      TX_STOP: if (w_tx_tick) begin
        w_tx_cnt_nx   = '0;
        w_tx_state_nx = TX_IDLE;
        w_tx_load     = ~w_tx_empty;
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
    if (w_tx_load) begin
      w_tx_pop       = 1'b1;
      w_tx_state_nx  = TX_START;
      w_tx_cnt_nx    = '0;
      w_tx_shift_nx  = w_tx_head;
      w_tx_div_nx    = w_cfg_div;
      w_tx_par_en_nx = w_cfg_par_en;
      w_tx_par_nx    = (^w_tx_head) ^ w_cfg_par_odd;
    end
    case (w_tx_state_nx)
      TX_START:  w_tx_line = 1'b0;
      TX_DATA:   w_tx_line = w_tx_shift_nx[0];
      TX_PARITY: w_tx_line = w_tx_par_nx;
      default:   w_tx_line = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e        r_rx_state, w_rx_state_nx;
  logic [DIV_W-1:0] r_rx_cnt, w_rx_cnt_nx;
  logic [DIV_W-1:0] r_rx_div, w_rx_div_nx;
  logic [2:0]       r_rx_bit, w_rx_bit_nx;
  logic [7:0]       w_rx_shift_nx;
  logic             r_rx_par_en, w_rx_par_en_nx;
  logic             r_rx_par_odd, w_rx_par_odd_nx;
  logic             r_rx_par_err, w_rx_par_err_nx;
  logic             r_rx_brk, w_rx_brk_nx;
  logic             w_rx_wr_nx;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic             w_rx_fall, w_rx_tick, w_rx_half;
  logic             w_rx_set_frm, w_rx_set_par;

  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_tick = (r_rx_cnt == r_rx_div - DIV_W'(1));
  assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1));

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_div     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_err <= 1'b0;
      r_rx_brk     <= 1'b0;
      r_rx_wr      <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nx;
      r_rx_cnt     <= w_rx_cnt_nx;
      r_rx_div     <= w_rx_div_nx;
      r_rx_bit     <= w_rx_bit_nx;
      r_rx_shift   <= w_rx_shift_nx;
      r_rx_par_en  <= w_rx_par_en_nx;
      r_rx_par_odd <= w_rx_par_odd_nx;
      r_rx_par_err <= w_rx_par_err_nx;
      r_rx_brk     <= w_rx_brk_nx;
      r_rx_wr      <= w_rx_wr_nx;
    end
  end

  // RX next state: mid-bit sampling; a low stop bit holds in STOP until idle
  always_comb begin
    w_rx_state_nx   = r_rx_state;
    w_rx_cnt_nx     = r_rx_cnt + DIV_W'(1);
    w_rx_div_nx     = r_rx_div;
    w_rx_bit_nx     = r_rx_bit;
    w_rx_shift_nx   = r_rx_shift;
    w_rx_par_en_nx  = r_rx_par_en;
    w_rx_par_odd_nx = r_rx_par_odd;
    w_rx_par_err_nx = r_rx_par_err;
    w_rx_brk_nx     = r_rx_brk;
    w_rx_wr_nx      = 1'b0;
    w_rx_set_frm    = 1'b0;
    w_rx_set_par    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nx = '0;
        if (w_rx_fall) begin
          w_rx_state_nx   = RX_START;
          w_rx_div_nx     = w_cfg_div;
          w_rx_par_en_nx  = w_cfg_par_en;
          w_rx_par_odd_nx = w_cfg_par_odd;
          w_rx_par_err_nx = 1'b0;
          w_rx_brk_nx     = 1'b0;
        end
      end
      RX_START: if (w_rx_half) begin
        w_rx_cnt_nx   = '0;
        w_rx_bit_nx   = '0;
        w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_rx_tick) begin
        w_rx_cnt_nx   = '0;
        w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
        w_rx_bit_nx   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_state_nx = r_rx_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (w_rx_tick) begin
        w_rx_cnt_nx     = '0;
        w_rx_par_err_nx = r_rx_s2 ^ (^r_rx_shift) ^ r_rx_par_odd;
        w_rx_state_nx   = RX_STOP;
      end
      RX_STOP: begin
        if (r_rx_brk) begin
          w_rx_cnt_nx = '0;
          if (r_rx_s2) w_rx_state_nx = RX_IDLE;
        end else if (w_rx_tick) begin
          w_rx_cnt_nx = '0;
          if (!r_rx_s2) begin
            w_rx_set_frm = 1'b1;
            w_rx_brk_nx  = 1'b1;
          end else if (r_rx_par_err) begin
            w_rx_set_par  = 1'b1;
            w_rx_state_nx = RX_IDLE;
          end else begin
            w_rx_wr_nx    = 1'b1;
            w_rx_state_nx = RX_IDLE;
          end
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- errors, status, interrupt ----------------
  logic       r_err_ovr, r_err_frm, w_err_par, r_irq;
  logic       w_set_ovr;
  logic [7:0] w_status;

  // A write into a full RX FIFO with no simultaneous pop is an overrun
  assign w_set_ovr = r_rx_wr & w_rx_full & (op != OP_POP);

  // Sticky error flags; a new event in the clearing cycle is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovr <= 1'b0;
      r_err_frm <= 1'b0;
    end else begin
      if (w_clr_err) begin
        r_err_ovr <= 1'b0;
        r_err_frm <= 1'b0;
      end
      if (w_set_ovr)    r_err_ovr <= 1'b1;
      if (w_rx_set_frm) r_err_frm <= 1'b1;
    end
  end

`ifdef UART_MMIO_PARITY_EN
  logic r_err_par;
  // Sticky parity error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_par <= 1'b0;
    end else begin
      if (w_clr_err)    r_err_par <= 1'b0;
      if (w_rx_set_par) r_err_par <= 1'b1;
    end
  end
  assign w_err_par = r_err_par;
  logic w_unused;
  assign w_unused = ^{wdata[31:8], w_tx_full, w_rx_empty};
`else
  assign w_err_par = 1'b0;
  logic w_unused;
  assign w_unused = ^{wdata[31:8], wdata[6:5], w_tx_full, w_rx_empty, w_rx_set_par};
`endif

  // Status byte assembly
  always_comb begin
    w_status                       = '0;
    w_status[STAT_OVR]             = r_err_ovr;
    w_status[STAT_FRM]             = r_err_frm;
    w_status[STAT_PAR]             = w_err_par;
    w_status[STAT_IRQ_EN]          = r_irq_en;
    w_status[STAT_SEL_LSB +: 4]    = r_baud_sel;
  end

  assign rdata = {w_status, w_rx_head, 8'(w_tx_count), 8'(w_rx_count)};

  // Registered interrupt: pending RX data or any error, gated by enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_irq_en & ((w_rx_count != '0) | r_err_ovr | r_err_frm | w_err_par);
  end
  assign irq = r_irq;

endmodule
`default_nettype wire
